// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM word/state types and the memory arbiter FSM state,
// kept here so the cache benches can probe the arbiter state by name.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache, D-side priority with locked
// D bursts. Define MEM_ARB_FAIR_EN to enable the instruction-fetch starvation guard.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        dlock,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  if (BURST_MAX < 1 || STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_param_check
    $error("mem_arbiter: BURST_MAX must be >= 1 and STARVE_LIMIT in 1..7");
  end

  arb_state_t state, nextState;
  logic [BW-1:0] burstCnt, nextBurstCnt;
  ramstate_t rstate;
  logic dReq;
  logic burstMore;
  logic favorI;

  assign rstate    = ramstate_t'(ramstate);
  assign dReq      = dREN | dWEN;
  // Another word stays inside the current grant only while the burst has room.
  assign burstMore = dlock && (int'(burstCnt) < BURST_MAX - 1);

  assign iload = ramload;
  assign dload = ramload;

`ifdef MEM_ARB_FAIR_EN
  logic [2:0] starveCnt;
  logic iDone, dDone;

  assign iDone  = (state == IGRANT) && iREN && (rstate == ACCESS);
  // A locked burst counts once, on its final word.
  assign dDone  = (state == DGRANT) && dReq && (rstate == ACCESS) && !burstMore;
  assign favorI = iREN && (int'(starveCnt) == STARVE_LIMIT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starveCnt <= '0;
    end else if (!iREN || iDone) begin
      starveCnt <= '0;
    end else if (dDone && (int'(starveCnt) < STARVE_LIMIT)) begin
      starveCnt <= starveCnt + 3'd1;
    end
  end
`else
  assign favorI = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      burstCnt <= '0;
    end else begin
      state    <= nextState;
      burstCnt <= nextBurstCnt;
    end
  end

  always_comb begin
    nextState    = state;
    nextBurstCnt = burstCnt;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    iwait        = 1'b1;
    dwait        = 1'b1;
    case (state)
      IDLE: begin
        if (favorI) begin
          nextState = IGRANT;
        end else if (dReq) begin
          nextState    = DGRANT;
          nextBurstCnt = '0;
        end else if (iREN) begin
          nextState = IGRANT;
        end
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          nextState = IDLE;
        end else if (rstate == ACCESS) begin
          iwait     = 1'b0;
          nextState = IDLE;
        end
      end
      DGRANT: begin
        // Enables track the live request so an abort releases RAM immediately.
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!dReq) begin
          nextState = IDLE;
        end else if (rstate == ACCESS) begin
          dwait = 1'b0;
          if (burstMore) begin
            nextBurstCnt = burstCnt + 1'b1;
          end else begin
            nextState = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: solo I read, D-over-I priority, locked burst,
// BUSY latency, abort, reset mid-transaction and the starvation guard.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic        dlock;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int n_checks;
  int n_fails;

  mem_arbiter #(.STARVE_LIMIT(4), .BURST_MAX(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .dlock(dlock), .daddr(daddr),
    .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  // clock/reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st();
    return {30'd0, dut.state};
  endfunction

  task automatic idle_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; dlock = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    nRST = 1'b0;
    idle_inputs();
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = 32'hDEADBEEF;
    ramstate = FREE;
    tick();
    chk("reset_state", st(), {30'd0, IDLE});
    chk("reset_iwait", {31'd0, iwait}, 32'd1);
    chk("reset_dwait", {31'd0, dwait}, 32'd1);
    chk("reset_ramaddr", ramaddr, 32'd0);
    nRST = 1'b1;
    tick();

    // solo I read, 0-wait RAM
    iREN = 1'b1; iaddr = 32'h40; ramstate = ACCESS;
    chk("i_idle_iwait", {31'd0, iwait}, 32'd1);
    chk("i_idle_ramren", {31'd0, ramREN}, 32'd0);
    tick();
    chk("i_grant_state", st(), {30'd0, IGRANT});
    chk("i_grant_ramren", {31'd0, ramREN}, 32'd1);
    chk("i_grant_ramaddr", ramaddr, 32'h40);
    chk("i_grant_iwait", {31'd0, iwait}, 32'd0);
    chk("i_grant_iload", iload, 32'hDEADBEEF);
    chk("i_grant_dwait", {31'd0, dwait}, 32'd1);
    tick();
    chk("i_done_state", st(), {30'd0, IDLE});
    iREN = 1'b0;
    tick();

    // simultaneous I and D: D wins, I follows after one IDLE cycle
    iREN = 1'b1; iaddr = 32'h44;
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
    tick();
    chk("sim_d_state", st(), {30'd0, DGRANT});
    chk("sim_d_ramwen", {31'd0, ramWEN}, 32'd1);
    chk("sim_d_ramren", {31'd0, ramREN}, 32'd0);
    chk("sim_d_ramstore", ramstore, 32'h1234);
    chk("sim_d_ramaddr", ramaddr, 32'h80);
    chk("sim_d_dwait", {31'd0, dwait}, 32'd0);
    chk("sim_d_iwait", {31'd0, iwait}, 32'd1);
    tick();
    dWEN = 1'b0;
    chk("sim_gap_state", st(), {30'd0, IDLE});
    chk("sim_gap_iwait", {31'd0, iwait}, 32'd1);
    tick();
    chk("sim_i_state", st(), {30'd0, IGRANT});
    chk("sim_i_ramaddr", ramaddr, 32'h44);
    chk("sim_i_iwait", {31'd0, iwait}, 32'd0);
    tick();
    iREN = 1'b0;
    tick();

    // locked burst of two words, then a fresh arbitration
    dREN = 1'b1; dlock = 1'b1; daddr = 32'h100; ramload = 32'hA5A5_0001;
    tick();
    chk("burst_w0_state", st(), {30'd0, DGRANT});
    chk("burst_w0_dwait", {31'd0, dwait}, 32'd0);
    chk("burst_w0_dload", dload, 32'hA5A5_0001);
    daddr = 32'h104; ramload = 32'hA5A5_0002;
    tick();
    chk("burst_w1_state", st(), {30'd0, DGRANT});
    chk("burst_w1_ramaddr", ramaddr, 32'h104);
    chk("burst_w1_ramren", {31'd0, ramREN}, 32'd1);
    chk("burst_w1_dwait", {31'd0, dwait}, 32'd0);
    tick();
    chk("burst_end_state", st(), {30'd0, IDLE});
    chk("burst_end_dwait", {31'd0, dwait}, 32'd1);
    tick();
    chk("burst_rearb_state", st(), {30'd0, DGRANT});
    idle_inputs();
    tick();
    chk("burst_abort_state", st(), {30'd0, IDLE});

    // BUSY for three cycles, then ACCESS
    dREN = 1'b1; ramstate = BUSY; daddr = 32'h200;
    tick();
    chk("lat_c1_dwait", {31'd0, dwait}, 32'd1);
    chk("lat_c1_ramren", {31'd0, ramREN}, 32'd1);
    tick();
    chk("lat_c2_dwait", {31'd0, dwait}, 32'd1);
    tick();
    chk("lat_c3_dwait", {31'd0, dwait}, 32'd1);
    chk("lat_c3_state", st(), {30'd0, DGRANT});
    ramstate = ACCESS;
    #1;
    chk("lat_access_dwait", {31'd0, dwait}, 32'd0);
    tick();
    chk("lat_done_state", st(), {30'd0, IDLE});
    dREN = 1'b0;
    tick();

    // abort: drop dREN mid-BUSY
    dREN = 1'b1; ramstate = BUSY;
    tick();
    chk("abort_grant_state", st(), {30'd0, DGRANT});
    dREN = 1'b0;
    #1;
    chk("abort_ramren", {31'd0, ramREN}, 32'd0);
    chk("abort_dwait", {31'd0, dwait}, 32'd1);
    tick();
    chk("abort_state", st(), {30'd0, IDLE});
    chk("abort_after_dwait", {31'd0, dwait}, 32'd1);

    // reset mid-transaction
    dWEN = 1'b1; daddr = 32'h300; dstore = 32'h55; ramstate = BUSY;
    tick();
    chk("rst_pre_ramwen", {31'd0, ramWEN}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("rst_state", st(), {30'd0, IDLE});
    chk("rst_ramwen", {31'd0, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_dwait", {31'd0, dwait}, 32'd1);
    nRST = 1'b1;
    ramstate = ACCESS;
    tick();
    chk("rst_rearb_state", st(), {30'd0, DGRANT});
    chk("rst_rearb_dwait", {31'd0, dwait}, 32'd0);
    tick();
    idle_inputs();
    tick();

    // starvation: D continuously requested with I pending
    dREN = 1'b1; iREN = 1'b1; iaddr = 32'h400; ramstate = ACCESS;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("starve_d%0d_state", k), st(), {30'd0, DGRANT});
      tick();
    end
    tick();
`ifdef MEM_ARB_FAIR_EN
    chk("starve_i_state", st(), {30'd0, IGRANT});
    chk("starve_i_iwait", {31'd0, iwait}, 32'd0);
    tick();
    chk("starve_cnt_clr", {29'd0, dut.starveCnt}, 32'd0);
`else
    chk("strict_d_state", st(), {30'd0, DGRANT});
    chk("strict_i_iwait", {31'd0, iwait}, 32'd1);
    tick();
`endif
    idle_inputs();
    tick();
    tick();
    chk("final_state", st(), {30'd0, IDLE});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
